move_mask_seq: RTL and testbench
================================

# move_mask_seq

Sequencer that computes per-direction legal simple-move and jump source masks for one side of a checkers position. It time-shares a single direction-selectable board-shift datapath across the four diagonal directions and streams one result per direction over a valid/ready interface. It sits between the CPU's move-generation instruction logic, which starts it and consumes masks, and the board registers.

## Interface
- No parameters.
- clock  in  1  sole clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; forces IDLE
- start  in  1  request; accepted only in IDLE
- side  in  1  0: men move up (UR, UL); 1: men move down (DR, DL)
- own  in  32  mover occupancy bitboard
- opp  in  32  opponent occupancy bitboard
- kings  in  32  king bitboard; masked with own internally
- busy  out  1  high from accepted start until done
- out_valid  out  1  result beat valid
- out_ready  in  1  consumer accepts beat
- out_dir  out  2  0 UR, 1 UL, 2 DR, 3 DL
- out_move  out  32  squares whose piece may step in out_dir
- out_jump  out  32  squares whose piece may capture in out_dir
- done  out  1  one-cycle pulse after the final beat
- any_jump  out  1  OR of all four jump masks; valid with done, held until next accepted start

## Operation
- Board: 32 playable squares, index 0 top-left, row r = s>>2, col c = s&3, 4 per row.
- Neighbours: even r: UL s-5 (none if c=0), UR s-4, DL s+3 (none if c=0), DR s+4. Odd r: UL s-4, UR s-3 (none if c=3), DL s+4, DR s+5 (none if c=3). Row 0 has no UL/UR; row 7 has no DL/DR.
- nbr_d(X)[s] = X[d-neighbour of s], or 1 if the neighbour does not exist.
- occ = own|opp. movers_d = own if d is a man direction for side, else own&kings.
- out_move = movers_d & ~nbr_d(occ).
- out_jump = movers_d & nbr_d(opp) & ~nbr_d(nbr_d(occ)).
- States: IDLE → SHIFT1 → SHIFT2 → EMIT → (next dir: SHIFT1 | after dir 3: DONE) → IDLE.
- IDLE: on start, latch own/opp/kings/side, clear any_jump, dir=0, set busy.
- SHIFT1: shifter applied to occ and opp; register nbr_d(occ), nbr_d(opp), out_move.
- SHIFT2: shifter applied to registered nbr_d(occ); register out_jump; any_jump |= (out_jump != 0).
- EMIT: out_valid=1; outputs held stable until out_ready; on transfer, dir++.
- DONE: done=1 for one cycle, busy falls, return to IDLE.
- start outside IDLE is ignored; input changes after acceptance have no effect.

## Timing
- Reset values: busy 0, out_valid 0, out_dir 0, out_move 0, out_jump 0, done 0, any_jump 0.
- Start sampled at edge 0; first out_valid in cycle 3. With out_ready held high, beats occur in cycles 3, 6, 9, 12, and done pulses in cycle 13.
- Backpressure stalls only in EMIT; each stalled cycle adds one cycle of latency.
- Reset mid-operation returns to IDLE immediately; a partial stream is abandoned with no done.

## Configuration
- MOVE_MASK_JUMP_EN defined: behaviour as above.
- MOVE_MASK_JUMP_EN undefined: SHIFT2 is removed; out_jump and any_jump are tied to 0. Beats occur in cycles 2, 4, 6, 8 and done pulses in cycle 9.

## Structure
- Shared package holds the direction encoding (DIR_UR..DIR_DL), the state enum, and BOARD_W=32.
- One sub-module, board_shift: combinational, inputs dir and X, output nbr_dir(X) with border bits forced to 1. The sequencer instantiates it exactly once.

## Test plan
- own=0x200, opp=0, kings=0, side=0 → UR move 0x200, UL move 0x200, DR/DL 0, all jumps 0, any_jump=0.
- own=0x200, opp=0x20, side=0 → UR move 0, jump 0x200; UL move 0x200; any_jump=1 (JUMP_EN).
- own=0x1, kings=0x1, side=0 → UR/UL/DL 0; DR move 0x1.
- Same as the first case with out_ready low for 5 cycles at each beat → outputs stable while stalled, done in cycle 33.
- Reset asserted in cycle 7 → all outputs 0 next cycle, no done; a new start gives the full stream.
- start pulsed while busy → ignored; stream and result values unchanged.

Source files
------------

// File: rtl/move_mask_seq_pkg.sv
// Shared types for the checkers move-mask sequencer: direction codes,
// sequencer states and the board neighbour lookup.
package move_mask_seq_pkg;

   localparam int BOARD_W = 32;

   typedef enum logic [1:0] {
      DIR_UR = 2'd0,
      DIR_UL = 2'd1,
      DIR_DR = 2'd2,
      DIR_DL = 2'd3
   } dir_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SHIFT1,
      S_SHIFT2,
      S_EMIT,
      S_DONE
   } state_e;

   typedef struct packed {
      logic       ok;
      logic [4:0] idx;
   } nbr_t;

   // Neighbour of square s in direction d; ok=0 when it falls off the board.
   function automatic nbr_t nbr_of(input logic [1:0] d, input int s);
      nbr_t nb;
      int   r, c, n;
      logic ok;
      r  = s / 4;
      c  = s % 4;
      ok = 1'b1;
      n  = 0;
      unique case (d)
         DIR_UR: begin
            if (r == 0) ok = 1'b0;
            else if (r % 2 == 0) n = s - 4;
            else if (c == 3) ok = 1'b0;
            else n = s - 3;
         end
         DIR_UL: begin
            if (r == 0) ok = 1'b0;
            else if (r % 2 == 1) n = s - 4;
            else if (c == 0) ok = 1'b0;
            else n = s - 5;
         end
         DIR_DR: begin
            if (r == 7) ok = 1'b0;
            else if (r % 2 == 0) n = s + 4;
            else if (c == 3) ok = 1'b0;
            else n = s + 5;
         end
         default: begin
            if (r == 7) ok = 1'b0;
            else if (r % 2 == 1) n = s + 4;
            else if (c == 0) ok = 1'b0;
            else n = s + 3;
         end
      endcase
      nb.ok  = ok;
      nb.idx = ok ? n[4:0] : 5'd0;
      return nb;
   endfunction

endpackage

// File: rtl/move_mask_seq_board_shift.sv
// Direction-selectable board shift: y[s] = x[nbr_dir(s)], or 1 where the
// neighbour is off the board. Lanes share one direction select.
module board_shift
   import move_mask_seq_pkg::*;
#(
   parameter int LANES = 1
) (
   input  logic [1:0]                        dir_i,
   input  logic [LANES-1:0][BOARD_W-1:0]     x_i,
   output logic [LANES-1:0][BOARD_W-1:0]     y_o
);

   nbr_t nb;

   always_comb begin
      y_o = '0;
      nb  = '0;
      for (int l = 0; l < LANES; l++) begin
         for (int s = 0; s < BOARD_W; s++) begin
            nb = nbr_of(dir_i, s);
            y_o[l][s] = nb.ok ? x_i[l][nb.idx] : 1'b1;
         end
      end
   end

endmodule

// File: rtl/move_mask_seq.sv
// Per-direction simple-move / jump mask sequencer for one checkers side.
// Jump masks and the SHIFT2 pass exist only with MOVE_MASK_JUMP_EN defined.
module move_mask_seq
   import move_mask_seq_pkg::*;
(
   input  logic               clock,
   input  logic               reset,
   input  logic               start,
   input  logic               side,
   input  logic [BOARD_W-1:0] own,
   input  logic [BOARD_W-1:0] opp,
   input  logic [BOARD_W-1:0] kings,
   output logic               busy,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [1:0]         out_dir,
   output logic [BOARD_W-1:0] out_move,
   output logic [BOARD_W-1:0] out_jump,
   output logic               done,
   output logic               any_jump
);

`ifdef MOVE_MASK_JUMP_EN
   localparam int LANES = 2;
`else
   localparam int LANES = 1;
`endif

   state_e             state_q;
   logic [1:0]         dir_q;
   logic               side_q;
   logic [BOARD_W-1:0] own_q, opp_q, kings_q;
   logic [BOARD_W-1:0] move_q;
   logic               busy_q, valid_q, done_q;

   logic [LANES-1:0][BOARD_W-1:0] sh_x, sh_y;
   logic [BOARD_W-1:0] movers, move_d;

   // Men step only toward the opponent; kings may use all four directions.
   assign movers = (dir_q[1] == side_q) ? own_q : (own_q & kings_q);
   assign move_d = movers & ~sh_y[0];

`ifdef MOVE_MASK_JUMP_EN
   logic [BOARD_W-1:0] nocc_q, nopp_q, jump_q, jump_d;
   logic               any_q;

   // SHIFT2 reuses lane 0 to look two squares out along the diagonal.
   assign sh_x[0] = (state_q == S_SHIFT2) ? nocc_q : (own_q | opp_q);
   assign sh_x[1] = opp_q;
   assign jump_d  = movers & nopp_q & ~sh_y[0];
   assign out_jump = jump_q;
   assign any_jump = any_q;
`else
   assign sh_x[0]  = own_q | opp_q;
   assign out_jump = '0;
   assign any_jump = 1'b0;
`endif

   board_shift #(.LANES(LANES)) u_shift (
      .dir_i (dir_q),
      .x_i   (sh_x),
      .y_o   (sh_y)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         dir_q   <= 2'd0;
         side_q  <= 1'b0;
         own_q   <= '0;
         opp_q   <= '0;
         kings_q <= '0;
         move_q  <= '0;
         busy_q  <= 1'b0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
`ifdef MOVE_MASK_JUMP_EN
         nocc_q  <= '0;
         nopp_q  <= '0;
         jump_q  <= '0;
         any_q   <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (start) begin
                  own_q   <= own;
                  opp_q   <= opp;
                  kings_q <= kings;
                  side_q  <= side;
                  dir_q   <= 2'd0;
                  busy_q  <= 1'b1;
`ifdef MOVE_MASK_JUMP_EN
                  any_q   <= 1'b0;
`endif
                  state_q <= S_SHIFT1;
               end
            end
            S_SHIFT1: begin
               move_q  <= move_d;
`ifdef MOVE_MASK_JUMP_EN
               nocc_q  <= sh_y[0];
               nopp_q  <= sh_y[1];
               state_q <= S_SHIFT2;
`else
               valid_q <= 1'b1;
               state_q <= S_EMIT;
`endif
            end
`ifdef MOVE_MASK_JUMP_EN
            S_SHIFT2: begin
               jump_q  <= jump_d;
               any_q   <= any_q | (|jump_d);
               valid_q <= 1'b1;
               state_q <= S_EMIT;
            end
`endif
            S_EMIT: begin
               if (out_ready) begin
                  valid_q <= 1'b0;
                  dir_q   <= dir_q + 2'd1;
                  if (dir_q == DIR_DL) begin
                     done_q  <= 1'b1;
                     busy_q  <= 1'b0;
                     state_q <= S_DONE;
                  end else begin
                     state_q <= S_SHIFT1;
                  end
               end
            end
            S_DONE:  state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy      = busy_q;
   assign out_valid = valid_q;
   assign out_dir   = dir_q;
   assign out_move  = move_q;
   assign done      = done_q;

endmodule

// File: tb/tb_move_mask_seq.sv
// Directed-vector bench for move_mask_seq; expectations follow the build
// (MOVE_MASK_JUMP_EN selects jump masks and 3-cycle beat spacing).
module tb_move_mask_seq;

   logic        clock, reset, start, side;
   logic [31:0] own, opp, kings;
   logic        busy, out_valid, out_ready, done, any_jump;
   logic [1:0]  out_dir;
   logic [31:0] out_move, out_jump;

   int total = 0;
   int bad   = 0;

`ifdef MOVE_MASK_JUMP_EN
   localparam bit JEN = 1'b1;
   localparam int PER = 3;
`else
   localparam bit JEN = 1'b0;
   localparam int PER = 2;
`endif

   move_mask_seq dut (
      .clock     (clock),
      .reset     (reset),
      .start     (start),
      .side      (side),
      .own       (own),
      .opp       (opp),
      .kings     (kings),
      .busy      (busy),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_dir   (out_dir),
      .out_move  (out_move),
      .out_jump  (out_jump),
      .done      (done),
      .any_jump  (any_jump)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic run_case(input string nm, input logic [31:0] o, p, k,
                           input logic sd, input logic [3:0][31:0] em,
                           input logic [3:0][31:0] ej, input logic ea,
                           input int stall, input bit poke);
      int cyc, beat, held, waited;
      logic [31:0] ejx;
      @(negedge clock);
      own = o; opp = p; kings = k; side = sd;
      start = 1'b1;
      out_ready = (stall == 0);
      @(posedge clock);
      #1;
      start = 1'b0;
      own = $urandom; opp = $urandom; kings = $urandom; side = ~sd;
      cyc = 0; beat = 0; held = 0; waited = 0;
      while (beat < 4 && waited < 300) begin
         @(negedge clock);
         cyc++;
         waited++;
         if (poke && cyc == 2) begin
            start = 1'b1;
            own = $urandom; opp = $urandom; kings = $urandom;
         end
         if (poke && cyc == 3) start = 1'b0;
         if (out_valid) begin
            ejx = JEN ? ej[beat] : 32'h0;
            chk($sformatf("%s_dir%0d", nm, beat), 32'(out_dir), 32'(beat));
            chk($sformatf("%s_mv%0d", nm, beat), out_move, em[beat]);
            chk($sformatf("%s_jp%0d", nm, beat), out_jump, ejx);
            chk($sformatf("%s_busy%0d", nm, beat), 32'(busy), 32'd1);
            if (held >= stall) begin
               out_ready = 1'b1;
               chk($sformatf("%s_cyc%0d", nm, beat), cyc,
                   PER * (beat + 1) + stall * (beat + 1));
               beat++;
               held = 0;
            end else begin
               out_ready = 1'b0;
               held++;
            end
         end else begin
            out_ready = (stall == 0);
            chk($sformatf("%s_nodone", nm), 32'(done), 32'd0);
         end
      end
      if (beat < 4) begin
         chk($sformatf("%s_timeout", nm), 32'd0, 32'd1);
      end else begin
         @(negedge clock);
         cyc++;
         chk($sformatf("%s_done", nm), 32'(done), 32'd1);
         chk($sformatf("%s_donecyc", nm), cyc, 4 * PER + 4 * stall + 1);
         chk($sformatf("%s_any", nm), 32'(any_jump), 32'(ea & JEN));
         @(negedge clock);
         chk($sformatf("%s_done1", nm), 32'(done), 32'd0);
         chk($sformatf("%s_idle", nm), 32'(busy), 32'd0);
         chk($sformatf("%s_anyhold", nm), 32'(any_jump), 32'(ea & JEN));
      end
   endtask

   initial begin
      int seen;
      reset = 1'b1; start = 1'b0; side = 1'b0;
      own = '0; opp = '0; kings = '0; out_ready = 1'b0;
      repeat (2) @(negedge clock);
      chk("rst_busy",  32'(busy), 32'd0);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_dir",   32'(out_dir), 32'd0);
      chk("rst_move",  out_move, 32'd0);
      chk("rst_jump",  out_jump, 32'd0);
      chk("rst_done",  32'(done), 32'd0);
      chk("rst_any",   32'(any_jump), 32'd0);
      reset = 1'b0;

      // mask order in literals: {DL, DR, UL, UR}
      run_case("man_up", 32'h200, 32'h0, 32'h0, 1'b0,
               {32'h0, 32'h0, 32'h200, 32'h200}, '0, 1'b0, 0, 1'b0);
      run_case("jump_ur", 32'h200, 32'h20, 32'h0, 1'b0,
               {32'h0, 32'h0, 32'h200, 32'h0},
               {32'h0, 32'h0, 32'h0, 32'h200}, 1'b1, 0, 1'b0);
      run_case("king_corner", 32'h1, 32'h0, 32'h1, 1'b0,
               {32'h0, 32'h1, 32'h0, 32'h0}, '0, 1'b0, 0, 1'b0);
      run_case("jump_dr", 32'h200, 32'h2000, 32'h2000, 1'b1,
               {32'h200, 32'h0, 32'h0, 32'h0},
               {32'h0, 32'h200, 32'h0, 32'h0}, 1'b1, 0, 1'b0);
      run_case("stall", 32'h200, 32'h0, 32'h0, 1'b0,
               {32'h0, 32'h0, 32'h200, 32'h200}, '0, 1'b0, 5, 1'b0);

      // abort mid-stream after a jump run left any_jump set
      run_case("pre_rst", 32'h200, 32'h20, 32'h0, 1'b0,
               {32'h0, 32'h0, 32'h200, 32'h0},
               {32'h0, 32'h0, 32'h0, 32'h200}, 1'b1, 0, 1'b0);
      @(negedge clock);
      own = 32'h200; opp = 32'h20; kings = '0; side = 1'b0;
      start = 1'b1; out_ready = 1'b1;
      @(posedge clock);
      #1 start = 1'b0;
      repeat (7) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      chk("ab_busy",  32'(busy), 32'd0);
      chk("ab_valid", 32'(out_valid), 32'd0);
      chk("ab_dir",   32'(out_dir), 32'd0);
      chk("ab_move",  out_move, 32'd0);
      chk("ab_jump",  out_jump, 32'd0);
      chk("ab_done",  32'(done), 32'd0);
      chk("ab_any",   32'(any_jump), 32'd0);
      reset = 1'b0;
      seen = 0;
      repeat (20) begin
         @(negedge clock);
         if (done || busy || out_valid) seen++;
      end
      chk("ab_quiet", seen, 0);

      run_case("post_rst", 32'h200, 32'h20, 32'h0, 1'b0,
               {32'h0, 32'h0, 32'h200, 32'h0},
               {32'h0, 32'h0, 32'h0, 32'h200}, 1'b1, 0, 1'b0);
      run_case("poke", 32'h200, 32'h20, 32'h0, 1'b0,
               {32'h0, 32'h0, 32'h200, 32'h0},
               {32'h0, 32'h0, 32'h0, 32'h200}, 1'b1, 0, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
